bitstream_decoder: RTL and testbench
====================================

# bitstream_decoder

Multi-channel stochastic-bitstream-to-binary converter for the bitstream network datapath. It counts ones on each channel over a window of 2^WINDOW_BITS valid samples and presents the per-channel results with a valid/ready handshake. Results are unipolar counts or bipolar signed values. The block sits at the output of the network (or of any generator chain), so decoding happens in hardware rather than in a bench.

## Interface
- CHANNELS, 2: number of independent bitstream lanes.
- WINDOW_BITS, 8: window length N = 2^WINDOW_BITS valid samples.
- BIPOLAR, 0: 0 gives unipolar output (count); 1 gives bipolar output (2·count − N, two's complement).

Derived widths: CW = WINDOW_BITS+1 (count, range 0..N); OW = WINDOW_BITS+2 (output).

- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request one window; sampled only in IDLE.
- continuous  in  1  sampled with start; 1 means back-to-back windows until deasserted.
- bits_in  in  CHANNELS  one stochastic bit per lane; bit c is lane c.
- bits_valid  in  1  bits_in is a sample this cycle.
- busy  out  1  high in ACCUM.
- out_valid  out  1  result held on out_value.
- out_ready  in  1  consumer accepts result when out_valid && out_ready.
- out_value  out  CHANNELS·OW  lane c occupies bits [c·OW +: OW].
- overrun  out  1  sticky; a result was overwritten before acceptance. Cleared only by rst.

## Operation
- States: IDLE, ACCUM, HOLD.
- IDLE, start=1: clear the sample counter and all lane counters, latch continuous into mode, go to ACCUM.
- ACCUM: on each cycle with bits_valid=1, sample counter +1 and lane counter c += bits_in[c]. Cycles with bits_valid=0 change nothing.
  - start is ignored here.
  - continuous is re-sampled into mode on every cycle, so deasserting it ends the run after the current window.
- Window end is the valid sample that brings the sample counter to N, including that sample. On that edge:
  - register all lane results into out_value and set out_valid=1.
  - mode=1: clear the counters and stay in ACCUM, so the next cycle's valid sample is the first sample of the next window (no gap).
  - mode=0: go to HOLD.
- HOLD: wait for out_valid && out_ready, then go to IDLE.
- out_valid clears on the edge where out_valid && out_ready, unless a new result is registered on that same edge; then out_valid stays 1 with the new data.
- Overrun: if a new result is registered while out_valid=1 and out_ready=0, the new result overwrites the old one and overrun is set.
- Output arithmetic:
  - unipolar: out = {1'b0, count}.
  - bipolar: out = (count << 1) − N in OW-bit two's complement. Range −N..+N, with no saturation needed.
- Counters never wrap: count ≤ N is guaranteed by the sample limit.

## Timing
- Reset values: state=IDLE, busy=0, out_valid=0, out_value=0, overrun=0, all counters 0.
- start in IDLE at edge k: busy=1 from cycle k+1. A sample presented in cycle k+1 is the first counted.
- Result latency: out_valid and out_value are visible the cycle after the edge that captures the Nth valid sample.
- Minimum single-shot window is N+1 cycles from the start edge to out_valid.
- After acceptance in HOLD, the block is in IDLE next cycle. start can be accepted there, giving a 1-cycle turnaround.
- out_value is stable while out_valid=1 and no new result is registered.
- rst mid-window or in HOLD: all state returns to reset values on that edge and the partial window is discarded.

## Test plan
- CHANNELS=2, WINDOW_BITS=8, unipolar, single-shot: lane0 all ones, lane1 all zeros, bits_valid=1 constant -> out_valid 257 cycles after start, lane0=256, lane1=0; busy low after the window.
- Lane0 alternating 1/0, bits_valid toggling every other cycle, 256 valid samples -> lane0=128 after 512 ACCUM cycles; samples on invalid cycles ignored.
- BIPOLAR=1: all ones -> +256 (0x100); all zeros -> −256 (0x300 in 10 bits); alternating -> 0.
- Continuous mode, out_ready=1: three windows with ones counts 10, 200, 256 -> three out_valid pulses exactly N cycles apart with those values, no sample lost between windows.
- Continuous mode, out_ready=0 -> second result overwrites the first, overrun=1 and stays 1 after out_ready rises; rst clears it.
- rst asserted at sample 100 of a window -> next cycle all outputs 0, state IDLE. A new start yields a correct full-window count, unaffected by the discarded partial.

Source files
------------

// File: rtl/bitstream_decoder.sv
// Multi-channel stochastic bitstream decoder: counts ones per lane over a window
// of 2^WINDOW_BITS valid samples and presents unipolar or bipolar results.

module bitstream_decoder_lane #(
    parameter int CW = 9
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    input  logic          bit_in,
    output logic [CW-1:0] sum
);
    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clr)
            count <= '0;
        else if (en && bit_in)
            count <= count + 1'b1;
    end

    // Includes the current sample so the window-closing sample is counted.
    assign sum = count + CW'(en & bit_in);
endmodule

module bitstream_decoder #(
    parameter int CHANNELS    = 2,
    parameter int WINDOW_BITS = 8,
    parameter bit BIPOLAR     = 1'b0,
    localparam int CW = WINDOW_BITS + 1,
    localparam int OW = WINDOW_BITS + 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   continuous,
    input  logic [CHANNELS-1:0]    bits_in,
    input  logic                   bits_valid,
    output logic                   busy,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [CHANNELS*OW-1:0] out_value,
    output logic                   overrun
);
    localparam int N_SAMPLES = 1 << WINDOW_BITS;

    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

    state_t                       state, state_next;
    logic [CW-1:0]                sample_cnt;
    logic                         mode;
    logic                         win_end, accept, clr, en;
    logic [CHANNELS-1:0][CW-1:0]  sum;
    logic [CHANNELS-1:0][OW-1:0]  result;

    assign win_end = (state == ACCUM) && bits_valid && (sample_cnt == CW'(N_SAMPLES - 1));
    assign accept  = out_valid && out_ready;
    assign en      = (state == ACCUM) && bits_valid;
    // Continuous runs clear on the window edge so the next sample starts a fresh window.
    assign clr     = ((state == IDLE) && start) || (win_end && mode);
    assign busy    = (state == ACCUM);

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = ACCUM;
            ACCUM:   if (win_end && !mode) state_next = HOLD;
            HOLD:    if (accept) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || clr)
            sample_cnt <= '0;
        else if (en)
            sample_cnt <= sample_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst)
            mode <= 1'b0;
        else if (((state == IDLE) && start) || (state == ACCUM))
            mode <= continuous;
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
        bitstream_decoder_lane #(.CW(CW)) u_lane (
            .clk    (clk),
            .rst    (rst),
            .clr    (clr),
            .en     (en),
            .bit_in (bits_in[c]),
            .sum    (sum[c])
        );

        if (BIPOLAR) begin : g_bip
            assign result[c] = {sum[c], 1'b0} - OW'(N_SAMPLES);
        end else begin : g_uni
            assign result[c] = {1'b0, sum[c]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_value <= '0;
            overrun   <= 1'b0;
        end else if (win_end) begin
            out_valid <= 1'b1;
            out_value <= result;
            if (out_valid && !out_ready)
                overrun <= 1'b1;
        end else if (accept) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_bitstream_decoder.sv
// Randomized directed bench for bitstream_decoder; unipolar and bipolar instances
// share stimulus and are checked against a window-sum reference model.

module tb_bitstream_decoder;
    localparam int CH = 2;
    localparam int WB = 8;
    localparam int N  = 1 << WB;
    localparam int OW = WB + 2;

    logic clk = 1'b0;
    logic rst, start, continuous, bits_valid, out_ready;
    logic [CH-1:0] bits_in;
    logic busy_u, oval_u, ovr_u, busy_b, oval_b, ovr_b;
    logic [CH*OW-1:0] val_u, val_b;

    int checks = 0;
    int errors = 0;
    int cnt[CH];
    int nv;
    int ticks;

    always #5 clk = ~clk;

    bitstream_decoder #(.CHANNELS(CH), .WINDOW_BITS(WB), .BIPOLAR(1'b0)) dut_u (
        .clk(clk), .rst(rst), .start(start), .continuous(continuous),
        .bits_in(bits_in), .bits_valid(bits_valid), .busy(busy_u),
        .out_valid(oval_u), .out_ready(out_ready), .out_value(val_u), .overrun(ovr_u));

    bitstream_decoder #(.CHANNELS(CH), .WINDOW_BITS(WB), .BIPOLAR(1'b1)) dut_b (
        .clk(clk), .rst(rst), .start(start), .continuous(continuous),
        .bits_in(bits_in), .bits_valid(bits_valid), .busy(busy_b),
        .out_valid(oval_b), .out_ready(out_ready), .out_value(val_b), .overrun(ovr_b));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [31:0] uni_exp(input int c);
        return 32'(c);
    endfunction

    function automatic logic [31:0] bip_exp(input int c);
        return 32'((2 * c - N) & ((1 << OW) - 1));
    endfunction

    task automatic chk_flags(input string tag, input logic busy, input logic ov, input logic ovr);
        chk({tag, "_busy_u"}, 32'(busy_u), 32'(busy));
        chk({tag, "_busy_b"}, 32'(busy_b), 32'(busy));
        chk({tag, "_oval_u"}, 32'(oval_u), 32'(ov));
        chk({tag, "_oval_b"}, 32'(oval_b), 32'(ov));
        chk({tag, "_ovr_u"}, 32'(ovr_u), 32'(ovr));
        chk({tag, "_ovr_b"}, 32'(ovr_b), 32'(ovr));
    endtask

    task automatic chk_vals(input string tag);
        for (int c = 0; c < CH; c++) begin
            chk($sformatf("%s_uni_lane%0d", tag, c), 32'(val_u[c*OW +: OW]), uni_exp(cnt[c]));
            chk($sformatf("%s_bip_lane%0d", tag, c), 32'(val_b[c*OW +: OW]), bip_exp(cnt[c]));
        end
    endtask

    task automatic do_start(input logic cont);
        start = 1'b1; continuous = cont; bits_valid = 1'b0;
        tick();
        start = 1'b0;
        chk("start_busy_u", 32'(busy_u), 32'd1);
        chk("start_busy_b", 32'(busy_b), 32'd1);
    endtask

    // pat: 0 lane0 ones/lane1 zeros, 1 lane0 alternating, 2 random, 3 lane0 ones for first k samples
    // vpat: 0 always valid, 1 valid on odd cycles, 2 random valid
    task automatic run_window(input int pat, input int vpat, input int k, input logic pend);
        logic v;
        logic [CH-1:0] b;
        for (int c = 0; c < CH; c++) cnt[c] = 0;
        nv = 0;
        ticks = 0;
        while (nv < N && ticks < 8 * N) begin
            case (vpat)
                0:       v = 1'b1;
                1:       v = (ticks % 2) == 1;
                default: v = 1'($urandom);
            endcase
            b = CH'($urandom);
            if (v) begin
                case (pat)
                    0: b = 2'b01;
                    1: b[0] = (nv % 2) == 0;
                    3: b[0] = nv < k;
                    default: ;
                endcase
                if (nv == N - 1) chk("pre_end_oval", 32'(oval_u), 32'(pend));
            end
            bits_valid = v;
            bits_in = b;
            // Start is ignored while a window is accumulating.
            start = 1'(ticks % 7 == 3);
            tick();
            ticks++;
            if (v) begin
                nv++;
                for (int c = 0; c < CH; c++) cnt[c] += int'(b[c]);
            end
        end
        start = 1'b0;
        bits_valid = 1'b0;
        chk("window_samples", 32'(nv), 32'(N));
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; continuous = 1'b0; bits_valid = 1'b0;
        out_ready = 1'b0; bits_in = '0;
        tick(); tick();
        chk_flags("reset", 1'b0, 1'b0, 1'b0);
        chk("reset_val_u", 32'(val_u), 32'd0);
        chk("reset_val_b", 32'(val_b), 32'd0);
        rst = 1'b0;
        tick();
        chk_flags("idle", 1'b0, 1'b0, 1'b0);

        // Single shot: lane0 all ones, lane1 all zeros.
        do_start(1'b0);
        run_window(0, 0, 0, 1'b0);
        chk("t1_latency", 32'(ticks), 32'(N));
        chk_flags("t1_done", 1'b0, 1'b1, 1'b0);
        chk_vals("t1");
        out_ready = 1'b1;
        tick();
        chk_flags("t1_accept", 1'b0, 1'b0, 1'b0);
        chk("t1_hold_val", 32'(val_u[0 +: OW]), 32'(N));

        // Alternating lane0 with bits_valid on every other cycle.
        do_start(1'b0);
        run_window(1, 1, 0, 1'b0);
        chk("t2_cycles", 32'(ticks), 32'(2 * N));
        chk_flags("t2_done", 1'b0, 1'b1, 1'b0);
        chk_vals("t2");
        tick();

        // Fully random bits and valid.
        do_start(1'b0);
        run_window(2, 2, 0, 1'b0);
        chk_flags("t3_done", 1'b0, 1'b1, 1'b0);
        chk_vals("t3");
        tick();
        chk_flags("t3_accept", 1'b0, 1'b0, 1'b0);

        // Continuous, consumer always ready: counts 10, 200, 256 back to back.
        do_start(1'b1);
        run_window(3, 0, 10, 1'b0);
        chk("t4a_period", 32'(ticks), 32'(N));
        chk_flags("t4a", 1'b1, 1'b1, 1'b0);
        chk_vals("t4a");
        run_window(3, 0, 200, 1'b0);
        chk("t4b_period", 32'(ticks), 32'(N));
        chk_flags("t4b", 1'b1, 1'b1, 1'b0);
        chk_vals("t4b");
        continuous = 1'b0;
        run_window(3, 0, 256, 1'b0);
        chk("t4c_period", 32'(ticks), 32'(N));
        chk_flags("t4c", 1'b0, 1'b1, 1'b0);
        chk_vals("t4c");
        tick();
        chk_flags("t4_end", 1'b0, 1'b0, 1'b0);

        // Continuous, consumer stalled: second result overwrites and flags overrun.
        out_ready = 1'b0;
        do_start(1'b1);
        run_window(2, 2, 0, 1'b0);
        chk_flags("t5a", 1'b1, 1'b1, 1'b0);
        chk_vals("t5a");
        continuous = 1'b0;
        run_window(2, 0, 0, 1'b1);
        chk_flags("t5b", 1'b0, 1'b1, 1'b1);
        chk_vals("t5b");
        out_ready = 1'b1;
        tick();
        chk_flags("t5_accept", 1'b0, 1'b0, 1'b1);
        tick();
        chk_flags("t5_sticky", 1'b0, 1'b0, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_flags("t5_rst", 1'b0, 1'b0, 1'b0);

        // Reset in the middle of a window discards the partial count.
        do_start(1'b0);
        bits_valid = 1'b1;
        bits_in = '1;
        for (int i = 0; i < 100; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bits_valid = 1'b0;
        chk_flags("t6_rst", 1'b0, 1'b0, 1'b0);
        chk("t6_val_u", 32'(val_u), 32'd0);
        chk("t6_val_b", 32'(val_b), 32'd0);
        do_start(1'b0);
        run_window(2, 2, 0, 1'b0);
        chk_flags("t6_done", 1'b0, 1'b1, 1'b0);
        chk_vals("t6");
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
